// File: rtl/window_3x3_if.sv
// window_3x3_if: configuration, upstream row-aligned pixel beats and downstream
// window stream for window_3x3.
// Optional macro WINDOW_COORD_EN adds the dn_col/dn_row window-centre signals.
interface window_3x3_if #(
  parameter int unsigned IMG_WIDTH = 8,
  parameter int unsigned DIM_WIDTH = 12
);
  logic [DIM_WIDTH-1:0]   cfg_cols;
  logic [DIM_WIDTH-1:0]   cfg_rows;
  logic                   cfg_set;
  logic [IMG_WIDTH-1:0]   up_row0_data;
  logic [IMG_WIDTH-1:0]   up_row1_data;
  logic [IMG_WIDTH-1:0]   up_row2_data;
  logic                   up_val;
  logic [9*IMG_WIDTH-1:0] dn_win;
  logic                   dn_val;
  logic                   dn_eol;
  logic                   dn_eof;
`ifdef WINDOW_COORD_EN
  logic [DIM_WIDTH-1:0]   dn_col;
  logic [DIM_WIDTH-1:0]   dn_row;

  modport master (
    output cfg_cols, cfg_rows, cfg_set,
    output up_row0_data, up_row1_data, up_row2_data, up_val,
    input  dn_win, dn_val, dn_eol, dn_eof, dn_col, dn_row
  );

  modport slave (
    input  cfg_cols, cfg_rows, cfg_set,
    input  up_row0_data, up_row1_data, up_row2_data, up_val,
    output dn_win, dn_val, dn_eol, dn_eof, dn_col, dn_row
  );
`else
  modport master (
    output cfg_cols, cfg_rows, cfg_set,
    output up_row0_data, up_row1_data, up_row2_data, up_val,
    input  dn_win, dn_val, dn_eol, dn_eof
  );

  modport slave (
    input  cfg_cols, cfg_rows, cfg_set,
    input  up_row0_data, up_row1_data, up_row2_data, up_val,
    output dn_win, dn_val, dn_eol, dn_eof
  );
`endif
endinterface

// File: rtl/window_3x3.sv
// window_3x3: builds a 3x3 neighbourhood from three row-aligned pixel streams
// and emits one registered packed window per interior pixel, with end-of-line
// and end-of-frame markers.
// Optional macro WINDOW_COORD_EN adds registered window-centre outputs dn_col/dn_row.
module window_3x3 #(
  parameter int unsigned IMG_WIDTH = 8,
  parameter int unsigned DIM_WIDTH = 12
) (
  input logic         clk,
  input logic         rst,
  window_3x3_if.slave bus
);
  localparam int unsigned WIN_WIDTH = 9 * IMG_WIDTH;

  // One image column: index 0 = oldest row (up_row2), index 2 = newest (up_row0)
  typedef logic [2:0][IMG_WIDTH-1:0] column_t;

  logic [DIM_WIDTH-1:0] cols_r;
  logic [DIM_WIDTH-1:0] rows_r;
  logic                 en_r;
  logic [DIM_WIDTH-1:0] col;
  logic [DIM_WIDTH-1:0] row;
  column_t              c0;
  column_t              c1;

  column_t              cur_c;
  logic [WIN_WIDTH-1:0] win_c;
  logic                 beat_c;
  logic                 last_col_c;
  logic                 last_row_c;
  logic                 qual_c;

  logic [WIN_WIDTH-1:0] dn_win_r;
  logic                 dn_val_r;
  logic                 dn_eol_r;
  logic                 dn_eof_r;
`ifdef WINDOW_COORD_EN
  logic [DIM_WIDTH-1:0] dn_col_r;
  logic [DIM_WIDTH-1:0] dn_row_r;
`endif

  // Beat acceptance, frame position decode and window assembly
  always_comb begin
    cur_c      = {bus.up_row0_data, bus.up_row1_data, bus.up_row2_data};
    beat_c     = en_r && bus.up_val;
    last_col_c = (col == cols_r - DIM_WIDTH'(1));
    last_row_c = (row == rows_r - DIM_WIDTH'(1));
    qual_c     = beat_c && (col >= DIM_WIDTH'(2)) && (row >= DIM_WIDTH'(2));
    win_c      = '0;
    for (int r = 0; r < 3; r++) begin
      win_c[(3*r + 0)*IMG_WIDTH +: IMG_WIDTH] = c0[r];
      win_c[(3*r + 1)*IMG_WIDTH +: IMG_WIDTH] = c1[r];
      win_c[(3*r + 2)*IMG_WIDTH +: IMG_WIDTH] = cur_c[r];
    end
  end

  // Config capture and column/row position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_r <= '0;
      rows_r <= '0;
      en_r   <= 1'b0;
      col    <= '0;
      row    <= '0;
    end else if (bus.cfg_set) begin
      cols_r <= bus.cfg_cols;
      rows_r <= bus.cfg_rows;
      en_r   <= (bus.cfg_cols >= DIM_WIDTH'(3)) && (bus.cfg_rows >= DIM_WIDTH'(3));
      col    <= '0;
      row    <= '0;
    end else if (beat_c) begin
      if (last_col_c) begin
        col <= '0;
        row <= last_row_c ? '0 : row + DIM_WIDTH'(1);
      end else begin
        col <= col + DIM_WIDTH'(1);
      end
    end
  end

  // Two-stage column history; survives frame wrap, cleared on restart
  always_ff @(posedge clk) begin
    if (rst || bus.cfg_set) begin
      c0 <= '0;
      c1 <= '0;
    end else if (beat_c) begin
      c0 <= c1;
      c1 <= cur_c;
    end
  end

  // Registered window output; dn_win holds between windows
  always_ff @(posedge clk) begin
    if (rst || bus.cfg_set) begin
      dn_win_r <= '0;
      dn_val_r <= 1'b0;
      dn_eol_r <= 1'b0;
      dn_eof_r <= 1'b0;
`ifdef WINDOW_COORD_EN
      dn_col_r <= '0;
      dn_row_r <= '0;
`endif
    end else begin
      dn_val_r <= qual_c;
      dn_eol_r <= qual_c && last_col_c;
      dn_eof_r <= qual_c && last_col_c && last_row_c;
      if (qual_c) begin
        dn_win_r <= win_c;
`ifdef WINDOW_COORD_EN
        dn_col_r <= col - DIM_WIDTH'(1);
        dn_row_r <= row - DIM_WIDTH'(1);
`endif
      end
    end
  end

  assign bus.dn_win = dn_win_r;
  assign bus.dn_val = dn_val_r;
  assign bus.dn_eol = dn_eol_r;
  assign bus.dn_eof = dn_eof_r;
`ifdef WINDOW_COORD_EN
  assign bus.dn_col = dn_col_r;
  assign bus.dn_row = dn_row_r;
`endif

endmodule

// File: tb/tb_window_3x3.sv
// tb_window_3x3: directed and randomized frames checked against an image-level
// model that emulates the two upstream row delays and reads each expected
// window directly out of a stored image.
module tb_window_3x3;
  localparam int unsigned W = 8;
  localparam int unsigned D = 12;
  localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_3x3_if #(.IMG_WIDTH(W), .DIM_WIDTH(D)) bus ();
  window_3x3 #(.IMG_WIDTH(W), .DIM_WIDTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  img [16][16];
  bit          model_en;
  logic [71:0] hold;
  logic [71:0] first_win;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cfg_set      = 1'b0;
    bus.up_val       = 1'b0;
    bus.up_row0_data = 8'($urandom);
    bus.up_row1_data = 8'($urandom);
    bus.up_row2_data = 8'($urandom);
  endtask

  // Restart with new geometry; optionally collide with an up_val beat
  task automatic do_cfg(input int cols, input int rows, input bit with_val);
    bus.cfg_cols     = D'(cols);
    bus.cfg_rows     = D'(rows);
    bus.cfg_set      = 1'b1;
    bus.up_val       = with_val;
    bus.up_row0_data = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    model_en = (cols >= 3) && (rows >= 3);
    hold     = '0;
    chk("cfg_val", 72'(bus.dn_val), 72'(0));
    chk("cfg_win", bus.dn_win, hold);
    chk("cfg_eol", 72'(bus.dn_eol), 72'(0));
  endtask

  // Stream an image (pattern 16*row+col or random) through emulated row delays
  task automatic run_frame(input int cols, input int rows, input bit pattern,
                           input bit gap, input int limit);
    int          nwin, neol, neof, nbeats, row, col;
    bit          q;
    logic [71:0] ew;
    nwin = 0; neol = 0; neof = 0;
    nbeats = cols * rows;
    if (limit > 0 && limit < nbeats) nbeats = limit;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        img[r][c] = pattern ? 8'(16*r + c) : 8'($urandom);
    for (int k = 0; k < nbeats; k++) begin
      row = k / cols;
      col = k % cols;
      bus.up_val       = 1'b1;
      bus.up_row0_data = img[row][col];
      bus.up_row1_data = (row >= 1) ? img[row-1][col] : 8'($urandom);
      bus.up_row2_data = (row >= 2) ? img[row-2][col] : 8'($urandom);
      q  = model_en && (row >= 2) && (col >= 2);
      ew = hold;
      if (q)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ew[(3*r + c)*8 +: 8] = img[row-2+r][col-2+c];
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk("dn_val", 72'(bus.dn_val), 72'(q));
      chk("dn_win", bus.dn_win, ew);
      hold = ew;
      if (bus.dn_val) begin
        nwin++;
        if (nwin == 1) first_win = bus.dn_win;
        if (bus.dn_eol) neol++;
        if (bus.dn_eof) neof++;
      end
      if (q) begin
        chk("dn_eol", 72'(bus.dn_eol), 72'(col == cols - 1));
        chk("dn_eof", 72'(bus.dn_eof), 72'((col == cols - 1) && (row == rows - 1)));
`ifdef WINDOW_COORD_EN
        chk("dn_col", 72'(bus.dn_col), 72'(col - 1));
        chk("dn_row", 72'(bus.dn_row), 72'(row - 1));
`endif
      end
      if (gap) begin
        @(posedge clk);
        @(negedge clk);
        chk("gap_val", 72'(bus.dn_val), 72'(0));
        chk("gap_win", bus.dn_win, hold);
      end
    end
    if (nbeats == cols * rows) begin
      chk("n_win", 72'(nwin), 72'(model_en ? (cols - 2) * (rows - 2) : 0));
      chk("n_eol", 72'(neol), 72'(model_en ? rows - 2 : 0));
      chk("n_eof", 72'(neof), 72'(model_en ? 1 : 0));
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.cfg_cols = '0;
    bus.cfg_rows = '0;
    idle_inputs();
    model_en  = 1'b0;
    hold      = '0;
    first_win = '0;
    repeat (3) @(negedge clk);
    chk("rst_val", 72'(bus.dn_val), 72'(0));
    chk("rst_win", bus.dn_win, 72'(0));
    chk("rst_eol", 72'(bus.dn_eol), 72'(0));
    chk("rst_eof", 72'(bus.dn_eof), 72'(0));
    rst = 1'b0;

    // Unconfigured after reset: beats ignored
    run_frame(4, 4, 1'b1, 1'b0, 0);

    // 4x4 pattern frame, continuous
    do_cfg(4, 4, 1'b0);
    first_win = '0;
    run_frame(4, 4, 1'b1, 1'b0, 0);
    chk("first_win_cont", first_win, FIRST_WIN);

    // 5x3 frame, continuous
    do_cfg(5, 3, 1'b0);
    run_frame(5, 3, 1'b0, 1'b0, 0);

    // 4x4 pattern frame with a gap after every beat
    do_cfg(4, 4, 1'b0);
    first_win = '0;
    run_frame(4, 4, 1'b1, 1'b1, 0);
    chk("first_win_gap", first_win, FIRST_WIN);

    // Too-narrow image disables the block: 64 beats, no windows
    do_cfg(2, 8, 1'b0);
    repeat (4) run_frame(2, 8, 1'b0, 1'b0, 0);

    // Mid-frame restart colliding with beat 6, then a fresh frame
    do_cfg(4, 4, 1'b0);
    run_frame(4, 4, 1'b1, 1'b0, 6);
    do_cfg(4, 4, 1'b1);
    first_win = '0;
    run_frame(4, 4, 1'b1, 1'b0, 0);
    chk("first_win_restart", first_win, FIRST_WIN);

    // Back-to-back frames across the counter wrap
    run_frame(4, 4, 1'b0, 1'b0, 0);
    run_frame(4, 4, 1'b1, 1'b0, 0);

    // Randomized geometries and gapping
    for (int i = 0; i < 6; i++) begin
      int cols, rows;
      cols = int'($urandom_range(8, 3));
      rows = int'($urandom_range(6, 3));
      do_cfg(cols, rows, 1'($urandom));
      run_frame(cols, rows, 1'b0, 1'($urandom), 0);
      run_frame(cols, rows, 1'b0, 1'b0, 0);
    end

    // Reset together with cfg_set: reset wins, block stays disabled
    rst          = 1'b1;
    bus.cfg_cols = D'(4);
    bus.cfg_rows = D'(4);
    bus.cfg_set  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_en = 1'b0;
    hold     = '0;
    chk("rstcfg_val", 72'(bus.dn_val), 72'(0));
    run_frame(4, 4, 1'b1, 1'b0, 0);

    // Mid-frame reset abandons the frame
    do_cfg(4, 4, 1'b0);
    run_frame(4, 4, 1'b0, 1'b0, 11);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_en = 1'b0;
    hold     = '0;
    chk("midrst_win", bus.dn_win, hold);
    do_cfg(4, 4, 1'b0);
    first_win = '0;
    run_frame(4, 4, 1'b1, 1'b0, 0);
    chk("first_win_rst", first_win, FIRST_WIN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
